bar_shift_pipe: RTL
===================

Name: bar_shift_pipe

Overview:
- Pipelined, parametrised barrel shifter for the execute datapath.
- Supports four shift modes: logical left, logical right, arithmetic right and rotate right.
- Accepts one operation per cycle through a valid/ready handshake and tolerates downstream backpressure.
- Produces a registered result plus a zero flag after a fixed latency that depends on the parameters.

Parameters:
- WIDTH, 16, data width; must be a power of two and at least 4.
- REG_EVERY, 2, number of log-shifter stages (1, 2, 4, ... bit positions) grouped between pipeline registers; range 1..SW.
- Derived, not overridable:
  - SW = clog2(WIDTH).
  - NSTG = ceil(SW/REG_EVERY), the number of pipeline register ranks.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation present on the in_* inputs.
- in_ready  out  1  block can accept an operation this cycle.
- in_data  in  WIDTH  operand.
- in_sh  in  SW+1  shift amount, range 0..2*WIDTH-1.
- in_op  in  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- out_valid  out  1  result present on out_data.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  high when out_data is all zeros.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset:
  - All stage valid bits clear.
  - out_valid=0, out_data=0, out_zero=0 (carry=0 when the optional feature is built in).
  - in_ready=1 in the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight operations; nothing is emitted afterwards.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline structure:
  - NSTG register ranks. Each rank holds valid, op, remaining shift bits, sign and partial data. The last rank drives out_*.
  - Rank k performs the stage shifts for bit positions [k*REG_EVERY .. min((k+1)*REG_EVERY, SW)-1] of in_sh.
- Latency: exactly NSTG cycles from input transfer to out_valid when there is no stall. The default parameters give 2.
- Flow control (bubble-collapsing):
  - Rank k loads when it is empty or when its content moves to rank k+1 in the same cycle.
  - The last rank moves when out_ready is high.
  - in_ready = rank0 empty, or rank0 advancing this cycle.
  - in_ready is a combinational function of out_ready and the valid bits only; it never depends on in_valid.
- Throughput and ordering:
  - With out_ready held at 1, throughput is one operation per cycle.
  - Order is preserved; no operation is dropped or duplicated.
- Stalls: while out_valid && !out_ready, out_data and out_zero hold stable.
- Shift semantics (n = in_sh):
  - LSL: data<<n, zero fill.
  - LSR: data>>n, zero fill.
  - ASR: data>>n, filled with the original in_data[WIDTH-1].
  - ROR: rotate right by n mod WIDTH.
  - n=0 passes data unchanged in every mode.
- Out-of-range amounts (n >= WIDTH):
  - LSL and LSR give 0.
  - ASR gives all copies of the sign bit.
  - ROR uses n mod WIDTH.
- out_zero is registered alongside out_data, with no added latency.
- Undefined in_op is not possible, since all four encodings are defined.

Optional Feature:
- Macro: BAR_SHIFT_CARRY_EN.
- When defined:
  - Adds output port out_carry (1 bit), registered with out_data.
  - out_carry is the last bit shifted out: in_data[WIDTH-n] for LSL, in_data[n-1] for LSR/ASR, and out_data[WIDTH-1] for ROR.
  - n=0 gives 0.
  - n>WIDTH gives 0 for LSL/LSR and the sign bit for ASR.
  - n==WIDTH gives in_data[0] for LSL and in_data[WIDTH-1] for LSR/ASR.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Default parameters; reset, then LSL of 16'h00F1 by 4 with out_ready=1 -> out_data=16'h0F10 exactly 2 cycles after transfer; out_zero=0; with the feature, carry=0.
- ASR of 16'h8010 by 4 -> 16'hF801. ASR by 20 -> 16'hFFFF. LSR of 16'h8010 by 16 -> 16'h0000 with out_zero=1; with the feature, carry=1.
- ROR of 16'h0001 by 1 -> 16'h8000. ROR by 17 -> 16'h8000. ROR by 0 -> 16'h0001.
- Back-to-back stream of 8 ops, out_ready held low for 3 cycles mid-stream -> results in order, out_data stable while stalled, in_ready drops only when all ranks are full, no loss.
- Assert rst with 2 ops in flight -> out_valid=0 next cycle, out_data=0, no stale result afterwards.
- Re-run the sweep with WIDTH=32 and REG_EVERY=1 (latency 5): random ops against a reference model, 1000 operations with random out_ready.

Source files
------------

// File: rtl/bar_shift_pipe.sv
// bar_shift_pipe: pipelined, parametrised barrel shifter (LSL, LSR, ASR, ROR).
//
// Structure
//   - A log shifter. Stage j shifts by 2**j when in_sh[j] is set.
//   - Stages are grouped REG_EVERY at a time between NSTG register ranks.
//     The last rank drives out_*.
//   - Ranks are bubble-collapsing. A rank loads when it is empty, or when its
//     content moves on in the same cycle.
//   - in_ready depends only on out_ready and the rank valid bits.
//
// Datapath tricks
//   - Every mode runs as a right shift. LSL bit-reverses the operand on entry
//     and bit-reverses the result in the last rank. This keeps one shifter
//     for all four modes.
//   - An amount n >= WIDTH (in_sh[SW] set) is resolved on entry for
//     LSL/LSR/ASR. The operand becomes its fill pattern and no stage shifts
//     afterwards. ROR ignores in_sh[SW] because it rotates by n mod WIDTH.
//
// Optional feature
//   - Define BAR_SHIFT_CARRY_EN to add out_carry.
//   - out_carry is the last bit shifted out, registered together with
//     out_data.
module bar_shift_pipe #(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [$clog2(WIDTH):0] in_sh,
    input  logic [1:0]             in_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_zero
`ifdef BAR_SHIFT_CARRY_EN
    ,
    output logic                   out_carry
`endif
);

    // Derived sizes; not overridable.
    localparam int SW   = $clog2(WIDTH);
    localparam int NSTG = (SW + REG_EVERY - 1) / REG_EVERY;

    typedef enum logic [1:0] {
        OP_LSL = 2'b00,
        OP_LSR = 2'b01,
        OP_ASR = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    // Contents of one pipeline rank, apart from its valid bit.
    typedef struct packed {
        op_e             op;
        logic [SW-1:0]   sh;     // in-range shift bits; each rank consumes its own slice
        logic            sign;   // original in_data MSB, used as the ASR fill
`ifdef BAR_SHIFT_CARRY_EN
        logic            carry;  // last bit shifted out so far
`endif
        logic [WIDTH-1:0] data;  // partial result (bit-reversed while op is LSL)
    } slot_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Bit reversal. Lets LSL reuse the right-shift datapath.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = d[WIDTH-1-i];
        end
        return r;
    endfunction

    // One past the highest in_sh bit that rank k handles.
    function automatic int stage_hi(input int k);
        return ((k + 1) * REG_EVERY > SW) ? SW : (k + 1) * REG_EVERY;
    endfunction

    // Apply the log-shifter stages [lo, hi) to one rank's contents.
    function automatic slot_t do_stage(input slot_t s, input int lo, input int hi);
        slot_t            r;
        int               amt;
        logic [WIDTH-1:0] low;
        logic [WIDTH-1:0] fill;
        r = s;
        for (int j = 0; j < SW; j++) begin
            if (j >= lo && j < hi && r.sh[j]) begin
                amt = 1 << j;
                // The bits about to leave the bottom, moved to the top.
                // ROR uses them as its fill; the MSB is the last bit out.
                low = r.data << (WIDTH - amt);
                if (r.op == OP_ROR) begin
                    fill = low;
                end else if (r.op == OP_ASR && r.sign) begin
                    fill = ~({WIDTH{1'b1}} >> amt);
                end else begin
                    fill = '0;
                end
`ifdef BAR_SHIFT_CARRY_EN
                r.carry = low[WIDTH-1];
`endif
                r.data = (r.data >> amt) | fill;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State and combinational nets
    // ------------------------------------------------------------------
    logic [NSTG-1:0] vld;           // rank valid bits
    slot_t           rank_q [NSTG]; // rank contents
    logic            zero_q;        // out_zero, registered with the last rank

    logic [NSTG-1:0] take;          // rank k loads this cycle
    logic [NSTG-1:0] src_vld;       // valid bit offered to rank k
    slot_t           pre;           // operand after entry conditioning
    slot_t           src    [NSTG]; // contents offered to rank k, before its stages
    slot_t           nxt    [NSTG]; // contents offered to rank k, after its stages

    // Load-enable chain. Rank k can load when out_ready is high or when any
    // rank from k to the last is empty, because every rank below the hole
    // moves up one place.
    always_comb begin
        // NOTE: every variable in a combinational block gets a value on every
        // path, here from the accumulator seed, so no latch is inferred.
        logic acc;
        acc = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            acc     = acc | ~vld[k];
            take[k] = acc;
        end
    end

    assign in_ready = take[0];

    // Entry conditioning: mode decode, LSL reversal, and resolving n >= WIDTH.
    always_comb begin
        pre.op   = op_e'(in_op);
        pre.sh   = in_sh[SW-1:0];
        pre.sign = in_data[WIDTH-1];
        pre.data = (op_e'(in_op) == OP_LSL) ? bit_rev(in_data) : in_data;
`ifdef BAR_SHIFT_CARRY_EN
        pre.carry = 1'b0;
`endif
        if (in_sh[SW]) begin
            if (op_e'(in_op) != OP_ROR) begin
`ifdef BAR_SHIFT_CARRY_EN
                // n == WIDTH: the last bit out is the far end of the operand.
                // This is in_data[0] for LSL (reversed MSB) and in_data[MSB]
                // for LSR/ASR. Beyond WIDTH only fill bits leave.
                if (in_sh[SW-1:0] == '0) begin
                    pre.carry = pre.data[WIDTH-1];
                end else begin
                    pre.carry = (op_e'(in_op) == OP_ASR) && in_data[WIDTH-1];
                end
`endif
                pre.data = ((op_e'(in_op) == OP_ASR) && in_data[WIDTH-1]) ? '1 : '0;
                pre.sh   = '0;
            end else begin
`ifdef BAR_SHIFT_CARRY_EN
                // ROR by exactly WIDTH: the data is unchanged, and the carry is
                // the result MSB.
                if (in_sh[SW-1:0] == '0) begin
                    pre.carry = in_data[WIDTH-1];
                end
`endif
            end
        end
    end

    // Per-rank source selection and stage logic. The last rank also undoes
    // the LSL reversal.
    always_comb begin
        src_vld[0] = in_valid;
        src[0]     = pre;
        for (int k = 1; k < NSTG; k++) begin
            src_vld[k] = vld[k-1];
            src[k]     = rank_q[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            nxt[k] = do_stage(src[k], k * REG_EVERY, stage_hi(k));
            if (k == NSTG - 1 && nxt[k].op == OP_LSL) begin
                nxt[k].data = bit_rev(nxt[k].data);
            end
        end
    end

    // Rank registers. Contents change only when a valid operation arrives,
    // so a stalled or drained output keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath ranks are reset as well as the valid bits,
            // because out_data, out_zero and the carry must read 0 after reset.
            vld    <= '0;
            zero_q <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                rank_q[k] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every rank sample the state
            // its neighbour held before this edge. This is what lets the whole
            // pipeline advance in one cycle.
            for (int k = 0; k < NSTG; k++) begin
                if (take[k]) begin
                    vld[k] <= src_vld[k];
                    if (src_vld[k]) begin
                        rank_q[k] <= nxt[k];
                    end
                end
            end
            if (take[NSTG-1] && src_vld[NSTG-1]) begin
                zero_q <= (nxt[NSTG-1].data == '0);
            end
        end
    end

    assign out_valid = vld[NSTG-1];
    assign out_data  = rank_q[NSTG-1].data;
    assign out_zero  = zero_q;
`ifdef BAR_SHIFT_CARRY_EN
    assign out_carry = rank_q[NSTG-1].carry;
`endif

endmodule
